washing_panel_input: RTL

Front-panel input conditioner that turns raw, bouncy user controls into the clean control inputs the washing-machine controller consumes: a one-cycle `start_pause` pulse, a latched 2-bit `mode_select`, and a filtered `door_sensor`. It sits between the board pins and `washing_machine_top`, on the same clock. It also locks mode changes while the machine is running.

---
 rtl/washing_panel_input.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/washing_panel_input.sv
// Front-panel conditioner: synchronizes and debounces the start/mode buttons, filters the door switch,
// and locks mode changes while the washing-machine controller is busy.
module washing_panel_input #(
    parameter int DEBOUNCE_CYCLES   = 16,
    parameter int DOOR_CLOSE_CYCLES = 8,
    parameter int CNT_W             = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start_raw,
    input  logic       btn_mode_raw,
    input  logic       door_raw,
    input  logic       busy,
    output logic       start_pause,
    output logic [1:0] mode_select,
    output logic       door_sensor,
    output logic       mode_reject
);

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_e;

    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] DEB_LIM   = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] OPEN_LIM  = CNT_W'(2);
    localparam logic [CNT_W-1:0] CLOSE_LIM = CNT_W'(DOOR_CLOSE_CYCLES);

    // bit 0 = start, bit 1 = mode, bit 2 = door
    logic [2:0] sync1_q, sync2_q;
    logic [1:0] press;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {door_raw, btn_mode_raw, btn_start_raw};
            sync2_q <= sync1_q;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_btn
        btn_state_e       state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             hit;
        logic             s;

        assign s        = sync2_q[g];
        assign press[g] = hit;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q <= RELEASED;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            hit     = 1'b0;
            case (state_q)
                RELEASED: begin
                    if (s) begin
                        state_d = PRESS_WAIT;
                        cnt_d   = ONE;
                    end
                end
                PRESS_WAIT: begin
                    if (!s) begin
                        state_d = RELEASED;
                        cnt_d   = '0;
                    end else if (cnt_q >= DEB_LIM) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                        hit     = 1'b1;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + ONE;
                    end
                end
                PRESSED: begin
                    if (!s) begin
                        state_d = RELEASE_WAIT;
                        cnt_d   = ONE;
                    end
                end
                RELEASE_WAIT: begin
                    if (s) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                    end else if (cnt_q >= DEB_LIM) begin
                        state_d = RELEASED;
                        cnt_d   = '0;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + ONE;
                    end
                end
                default: begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    logic       start_pause_q, mode_reject_q;
    logic [1:0] mode_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_pause_q <= 1'b0;
            mode_reject_q <= 1'b0;
            mode_q        <= 2'b00;
        end else begin
            start_pause_q <= press[0];
            mode_reject_q <= press[1] & busy;
            if (press[1] && !busy) begin
                mode_q <= mode_q + 2'd1;
            end
        end
    end

    // Opening is accepted after 2 samples, closing only after the full close window.
    logic             door_q, door_d;
    logic [CNT_W-1:0] dcnt_q, dcnt_d, dcnt_inc, door_lim;

    assign dcnt_inc = dcnt_q + ONE;
    assign door_lim = door_q ? OPEN_LIM : CLOSE_LIM;

    always_comb begin
        door_d = door_q;
        dcnt_d = dcnt_q;
        if (sync2_q[2] == door_q) begin
            dcnt_d = '0;
        end else if (dcnt_inc >= door_lim) begin
            door_d = ~door_q;
            dcnt_d = '0;
        end else begin
            dcnt_d = dcnt_inc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            door_q <= 1'b0;
            dcnt_q <= '0;
        end else begin
            door_q <= door_d;
            dcnt_q <= dcnt_d;
        end
    end

    assign start_pause = start_pause_q;
    assign mode_reject = mode_reject_q;
    assign mode_select = mode_q;
    assign door_sensor = door_q;

endmodule
